// File: rtl/stream_pass_pkg.sv
// Shared types and width helpers for the multi-pass stream sequencer.
// Holds the FSM state enum, default geometry and clog2-based width helpers.
package stream_pass_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    localparam int DEF_IMG_W    = 512;
    localparam int DEF_IMG_H    = 512;
    localparam int FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data (head), full, empty, count.
module axis_sync_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              do_wr;
    logic              do_rd;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rd_data = mem[rptr];

    // A read frees the slot this cycle, so a write at full still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/stream_pass_sequencer.sv
// Multi-pass frame sequencer: one input frame per pass, per-pass clock enables,
// buffered final-pass output with TLAST generation, input TLAST checking.
// Ports: clk, rst, enable; s_* input stream; pass_done, stage_en, pass_idx;
// proc_* final-stage results; m_* output stream; frame_done, tlast_err, ovf_err.
module stream_pass_sequencer
    import stream_pass_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int NUM_PASSES = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int PF_THRESH  = 48,
    parameter bit REPEAT_ALL = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [DATA_W-1:0]                s_tdata,
    input  logic                             s_tvalid,
    input  logic                             s_tlast,
    output logic                             s_tready,
    input  logic [NUM_PASSES-1:0]            pass_done,
    output logic [NUM_PASSES-1:0]            stage_en,
    output logic [width_of(NUM_PASSES)-1:0]  pass_idx,
    input  logic                             proc_tvalid,
    input  logic [DATA_W-1:0]                proc_tdata,
    output logic [DATA_W-1:0]                m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic                             frame_done,
    output logic                             tlast_err,
    output logic                             ovf_err
);

    localparam int FRAME = frame_pixels(IMG_W, IMG_H);
    localparam int CW    = width_of(FRAME);
    localparam int PW    = width_of(NUM_PASSES);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0]  LAST_PIX   = CW'(FRAME - 1);
    localparam logic [PW-1:0]  FINAL_PASS = PW'(NUM_PASSES - 1);
    localparam logic [FCW-1:0] PF         = FCW'(PF_THRESH);

    state_t                state;
    state_t                state_d;
    logic [PW-1:0]         pass_q;
    logic [PW-1:0]         pass_d;
    logic                  in_done;
    logic                  in_done_d;
    logic [CW-1:0]         in_cnt;
    logic [CW-1:0]         out_cnt;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [NUM_PASSES-1:0] stage_en_d;
    logic                  final_pass;
    logic                  in_fire;
    logic                  in_last;
    logic                  in_end;
    logic                  out_fire;
    logic                  out_end;
    logic                  unused_ok;

    // Pixel data is routed to the stages by the parent; the final pass has no done.
    assign unused_ok = ^{s_tdata, pass_done[NUM_PASSES-1]};

    assign final_pass = (pass_q == FINAL_PASS);
    assign pass_idx   = pass_q;

    assign s_tready = enable && (state == RUN)
                   && !(final_pass && (fifo_count >= PF))
                   && !(final_pass && in_done);

    assign in_fire = s_tvalid && s_tready;
    assign in_last = (in_cnt == LAST_PIX);
    // Early s_tlast closes the frame exactly like the last pixel does.
    assign in_end  = in_fire && (in_last || s_tlast);

    assign m_tvalid = !fifo_empty;
    assign out_fire = m_tvalid && m_tready;
    assign m_tlast  = m_tvalid && (out_cnt == LAST_PIX);
    assign out_end  = out_fire && (out_cnt == LAST_PIX);

    axis_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (proc_tvalid),
        .wr_data (proc_tdata),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pass_q  <= '0;
            in_done <= 1'b0;
        end else begin
            state   <= state_d;
            pass_q  <= pass_d;
            in_done <= in_done_d;
        end
    end

    always_comb begin
        state_d   = state;
        pass_d    = pass_q;
        in_done_d = in_done;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    pass_d  = '0;
                end
            end
            RUN: begin
                if (!final_pass) begin
                    if (in_end) state_d = WAIT;
                end else begin
                    if (in_end) in_done_d = 1'b1;
                    if (out_end) begin
                        in_done_d = 1'b0;
                        if (REPEAT_ALL) pass_d = '0;
                    end
                end
            end
            WAIT: begin
                if (pass_done[pass_q]) begin
                    state_d = RUN;
                    pass_d  = pass_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stage_en_d = '0;
        for (int k = 0; k < NUM_PASSES; k++) begin
            stage_en_d[k] = enable && (state != IDLE) && (pass_q == PW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            stage_en   <= '0;
            frame_done <= 1'b0;
            tlast_err  <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            stage_en   <= stage_en_d;
            frame_done <= out_end;
            if (in_fire) in_cnt <= in_end ? '0 : in_cnt + 1'b1;
            if (out_fire) out_cnt <= out_end ? '0 : out_cnt + 1'b1;
            if (in_fire && (s_tlast != in_last)) tlast_err <= 1'b1;
            // Dropped only when no read frees a slot this cycle.
            if (proc_tvalid && fifo_full && !out_fire) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_pass_sequencer.sv
// Directed/randomized bench for stream_pass_sequencer (4x2 frame, 2 passes).
// Expected output order and handshake levels come from a queue-based model.
module tb_stream_pass_sequencer;

    localparam int DW    = 24;
    localparam int NP    = 2;
    localparam int NPIX  = 8;
    localparam int DEPTH = 8;
    localparam int PF    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [NP-1:0] pass_done = '0;
    logic [NP-1:0] stage_en;
    logic [0:0]    pass_idx;
    logic          proc_tvalid = 1'b0;
    logic [DW-1:0] proc_tdata = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          frame_done;
    logic          tlast_err;
    logic          ovf_err;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] q[$];

    stream_pass_sequencer #(
        .DATA_W     (DW),
        .IMG_W      (4),
        .IMG_H      (2),
        .NUM_PASSES (NP),
        .FIFO_DEPTH (DEPTH),
        .PF_THRESH  (PF),
        .REPEAT_ALL (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .pass_done   (pass_done),
        .stage_en    (stage_en),
        .pass_idx    (pass_idx),
        .proc_tvalid (proc_tvalid),
        .proc_tdata  (proc_tdata),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .frame_done  (frame_done),
        .tlast_err   (tlast_err),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rdy"},  32'(s_tready),   0);
        chk({tag, "_en"},   32'(stage_en),   0);
        chk({tag, "_idx"},  32'(pass_idx),   0);
        chk({tag, "_mv"},   32'(m_tvalid),   0);
        chk({tag, "_ml"},   32'(m_tlast),    0);
        chk({tag, "_fd"},   32'(frame_done), 0);
        chk({tag, "_tle"},  32'(tlast_err),  0);
        chk({tag, "_ovf"},  32'(ovf_err),    0);
    endtask

    // Statistics pass: beats until tl_at (s_tlast there), then WAIT and pass_done.
    task automatic pass0(input int tl_at);
        for (int i = 0; i < NPIX; i++) begin
            repeat ($urandom_range(0, 2)) tick;
            chk("p0_rdy", 32'(s_tready), 1);
            s_tvalid = 1'b1;
            s_tdata  = DW'($urandom);
            s_tlast  = (i == tl_at);
            tick;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            if (i == tl_at) break;
        end
        chk("wait_rdy", 32'(s_tready), 0);
        chk("wait_idx", 32'(pass_idx), 0);
        repeat (3) tick;
        chk("wait_rdy3", 32'(s_tready), 0);
        pass_done = 2'b01;
        tick;
        pass_done = '0;
        chk("p1_rdy", 32'(s_tready), 1);
        chk("p1_idx", 32'(pass_idx), 1);
        tick;
        chk("p1_en", 32'(stage_en), 2);
    endtask

    // Output pass: model tracks FIFO contents, input and output beat counts.
    task automatic final_pass(input bit stall);
        int in_sent  = 0;
        int out_seen = 0;
        int hold     = 3;
        int cyc      = 0;
        bit in_f;
        bit out_f;
        bit exp_rdy;
        bit exp_v;
        q.delete();
        while (out_seen < NPIX && cyc < 400) begin
            cyc++;
            exp_rdy = (q.size() < PF) && (in_sent < NPIX);
            exp_v   = (q.size() > 0);
            chk("f_rdy",  32'(s_tready), 32'(exp_rdy));
            chk("f_vld",  32'(m_tvalid), 32'(exp_v));
            chk("f_last", 32'(m_tlast),
                32'(exp_v && (out_seen == NPIX - 1)));
            if (exp_v) chk("f_data", 32'(m_tdata), 32'(q[0]));
            s_tvalid    = (in_sent < NPIX) && ($urandom_range(0, 3) != 0);
            s_tlast     = (in_sent == NPIX - 1);
            s_tdata     = DW'($urandom);
            in_f        = s_tvalid && exp_rdy;
            proc_tvalid = in_f;
            proc_tdata  = DW'($urandom);
            if (stall && (in_sent < PF || hold > 0)) begin
                m_tready = 1'b0;
                if (in_sent >= PF) hold--;
            end else begin
                m_tready = 1'($urandom_range(0, 1));
            end
            out_f = exp_v && m_tready;
            tick;
            if (out_f) begin
                void'(q.pop_front());
                out_seen++;
            end
            if (in_f) begin
                q.push_back(proc_tdata);
                in_sent++;
            end
        end
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        proc_tvalid = 1'b0;
        m_tready    = 1'b0;
        chk("f_count", 32'(out_seen), NPIX);
        chk("f_done",  32'(frame_done), 1);
        chk("f_rep_idx", 32'(pass_idx), 0);
        chk("f_rep_rdy", 32'(s_tready), 1);
        tick;
        chk("f_done_pulse", 32'(frame_done), 0);
        chk("f_rep_en", 32'(stage_en), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick;
        reset_check("rst0");

        rst    = 1'b0;
        enable = 1'b1;
        tick;
        chk("run_rdy", 32'(s_tready), 1);
        chk("run_en0", 32'(stage_en), 0);
        tick;
        chk("run_en1", 32'(stage_en), 1);

        pass0(NPIX - 1);
        final_pass(1'b1);
        chk("tle_clean", 32'(tlast_err), 0);

        pass0(4);
        chk("tle_early", 32'(tlast_err), 1);
        final_pass(1'b0);
        chk("tle_sticky", 32'(tlast_err), 1);

        pass0(NPIX - 1);
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid    = 1'b1;
            s_tdata     = DW'($urandom);
            proc_tvalid = 1'b1;
            proc_tdata  = DW'($urandom);
            tick;
        end
        s_tvalid    = 1'b0;
        proc_tvalid = 1'b0;
        chk("pre_rst_mv", 32'(m_tvalid), 1);
        rst = 1'b1;
        tick;
        reset_check("rst1");
        rst = 1'b0;
        tick;
        tick;

        enable = 1'b0;
        #1;
        chk("dis_rdy", 32'(s_tready), 0);
        tick;
        chk("dis_en", 32'(stage_en), 0);
        enable = 1'b1;
        tick;
        chk("ren_en", 32'(stage_en), 1);

        pass0(NPIX - 1);
        q.delete();
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            proc_tvalid = 1'b1;
            proc_tdata  = DW'($urandom);
            q.push_back(proc_tdata);
            tick;
        end
        chk("full_ovf", 32'(ovf_err), 0);
        chk("full_mv", 32'(m_tvalid), 1);
        proc_tdata = 24'hABCDEF;
        tick;
        proc_tvalid = 1'b0;
        chk("ovf_set", 32'(ovf_err), 1);
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_data", 32'(m_tdata), 32'(q[0]));
            chk("ovf_last", 32'(m_tlast), 32'(i == DEPTH - 1));
            void'(q.pop_front());
            tick;
        end
        m_tready = 1'b0;
        chk("ovf_empty", 32'(m_tvalid), 0);
        chk("ovf_fd", 32'(frame_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
